// File: rtl/aes_dec_ark_mixw_if.sv
// Block handshake bundle for the decryption round back-end: upstream block
// (state, key, last) in, round result out, each with its own valid/ready pair.
interface aes_dec_ark_mixw_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic         last_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] state_o;

    modport master (
        output in_valid_i, state_i, key_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o
    );

    modport slave (
        input  in_valid_i, state_i, key_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o
    );
endinterface

// File: rtl/aes_dec_ark_mixw.sv
// Column-serial AES decryption round back-end: AddRoundKey, then InvMixColumns
// on one 32-bit column per cycle; the final round skips InvMixColumns.
module aes_dec_ark_mixw #(
    parameter int NCOL = 4
) (
    input  logic              clk,
    input  logic              nreset,
    aes_dec_ark_mixw_if.slave bus
);
    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    fsm_q;
    logic [CW-1:0] col_cnt;
    logic [127:0]  buf_q;
    logic [31:0]   col_in;
    logic [31:0]   col_out;
    logic          accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse MixColumns on one column; 9/b/d/e built from a shared doubling chain.
    function automatic logic [31:0] inv_mixw(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign bus.in_ready_o  = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready_i);
    assign bus.out_valid_o = (fsm_q == DONE);
    assign bus.state_o     = buf_q;
    assign accept          = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        col_in = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (col_cnt == CW'(c)) col_in = buf_q[127-32*c -: 32];
        end
    end

    assign col_out = inv_mixw(col_in);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fsm_q   <= IDLE;
            col_cnt <= '0;
            buf_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (accept) begin
                        buf_q   <= bus.state_i ^ bus.key_i;
                        col_cnt <= '0;
                        fsm_q   <= bus.last_i ? DONE : MIX;
                    end else if (fsm_q == DONE && bus.out_ready_i) begin
                        fsm_q <= IDLE;
                    end
                end
                MIX: begin
                    // In-place update: columns not yet reached keep their ARK value.
                    for (int c = 0; c < NCOL; c++) begin
                        if (col_cnt == CW'(c)) buf_q[127-32*c -: 32] <= col_out;
                    end
                    if (col_cnt == CW'(NCOL - 1)) begin
                        col_cnt <= '0;
                        fsm_q   <= DONE;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_dec_ark_mixw.sv
// Self-checking bench for aes_dec_ark_mixw: cycle-level behavioural model plus
// known-answer, backpressure, back-to-back and async-reset scenarios.
module tb_aes_dec_ark_mixw;
    logic clk    = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    aes_dec_ark_mixw_if bus ();

    aes_dec_ark_mixw #(.NCOL(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    // Generic shift-and-add GF(2^8) multiply, polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] m_invmix(input logic [31:0] col);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] b [4];
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
        for (int r = 0; r < 4; r++) begin
            b[r] = 8'h00;
            for (int k = 0; k < 4; k++) b[r] = b[r] ^ gmul(coef[(k - r) & 3], a[k]);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic l);
        logic [127:0] r;
        r = s ^ k;
        if (!l) begin
            for (int c = 0; c < 4; c++) r[127-32*c -: 32] = m_invmix(r[127-32*c -: 32]);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: result register, busy countdown, valid flag.
    logic         m_valid = 1'b0;
    int           m_cnt   = 0;
    logic [127:0] m_data  = '0;
    logic         m_acc   = 1'b0;

    initial forever begin
        @(posedge clk or negedge nreset);
        if (!nreset) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            m_data  = '0;
            m_acc   = 1'b0;
        end else begin
            m_acc = bus.in_valid_i &&
                    ((!m_valid && m_cnt == 0) || (m_valid && bus.out_ready_i));
            if (m_valid && bus.out_ready_i) m_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1'b1;
            end
            if (m_acc) begin
                m_data = m_round(bus.state_i, bus.key_i, bus.last_i);
                if (bus.last_i) m_valid = 1'b1;
                else            m_cnt   = 4;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("out_valid", 128'(bus.out_valid_o), 128'(m_valid));
        chk("in_ready", 128'(bus.in_ready_o),
            128'((!m_valid && m_cnt == 0) || (m_valid && bus.out_ready_i)));
        if (m_valid) chk("state_o", bus.state_o, m_data);
    end

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        int t;
        t = 0;
        bus.state_i    = s;
        bus.key_i      = k;
        bus.last_i     = l;
        bus.in_valid_i = 1'b1;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!m_acc && t < 100);
        if (!m_acc) chk("accept_timeout", 128'(0), 128'(1));
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int exp_lat);
        int n;
        n = 1;
        while (!bus.out_valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 128'(n), 128'(exp_lat));
    endtask

    initial begin
        logic [127:0] s, k, a_exp;
        bus.in_valid_i  = 1'b0;
        bus.state_i     = '0;
        bus.key_i       = '0;
        bus.last_i      = 1'b0;
        bus.out_ready_i = 1'b1;

        chk("model_gmul", 128'(gmul(8'h57, 8'h13)), 128'h fe);
        chk("model_kat", m_round(KAT_IN, '0, 1'b0), KAT_OUT);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
        chk("rst_state_o", bus.state_o, '0);
        nreset = 1'b1;
        @(posedge clk); #1;

        send(KAT_IN, '0, 1'b0);
        wait_valid("kat", 5);
        chk("kat_state", bus.state_o, KAT_OUT);

        send(128'h00112233_44556677_8899aabb_ccddeeff,
             128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1);
        wait_valid("ark", 1);
        chk("ark_state", bus.state_o, 128'h00102030_40506070_8090a0b0_c0d0e0f0);

        send('0, 128'h8e4da1bc_00000000_00000000_00000000, 1'b0);
        wait_valid("comb", 5);
        chk("comb_state", bus.state_o, 128'hdb135345_00000000_00000000_00000000);

        // Backpressure with a second block waiting upstream.
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        a_exp = s ^ k;
        for (int c = 0; c < 4; c++) a_exp[127-32*c -: 32] = m_invmix(a_exp[127-32*c -: 32]);
        send(s, k, 1'b0);
        wait_valid("bp", 5);
        bus.state_i    = KAT_IN;
        bus.key_i      = '0;
        bus.last_i     = 1'b0;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_state", bus.state_o, a_exp);
            chk("bp_hold_ready", 128'(bus.in_ready_o), 128'(0));
            chk("bp_hold_valid", 128'(bus.out_valid_o), 128'(1));
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk("bp_drop_valid", 128'(bus.out_valid_o), 128'(0));
        wait_valid("bp_next", 5);
        chk("bp_next_state", bus.state_o, KAT_OUT);
        @(posedge clk); #1;

        // Back-to-back final-round blocks.
        bus.last_i     = 1'b1;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            bus.state_i = s;
            bus.key_i   = k;
            @(posedge clk); #1;
            chk("b2b_valid", 128'(bus.out_valid_o), 128'(1));
            chk("b2b_state", bus.state_o, s ^ k);
        end
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while column 2 is next.
        send(KAT_IN, '0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        nreset = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("arst_in_ready", 128'(bus.in_ready_o), 128'(1));
        chk("arst_state_o", bus.state_o, '0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 128'(bus.in_ready_o), 128'(1));
        chk("post_rst_state", bus.state_o, '0);
        send(KAT_IN, '0, 1'b0);
        wait_valid("post_rst", 5);
        chk("post_rst_kat", bus.state_o, KAT_OUT);
        @(posedge clk); #1;

        // Randomized traffic with upstream hold-while-stalled discipline.
        for (int i = 0; i < 1500; i++) begin
            if (!bus.in_valid_i || m_acc) begin
                bus.in_valid_i = ($urandom_range(0, 9) < 6);
                bus.state_i    = {$urandom, $urandom, $urandom, $urandom};
                bus.key_i      = {$urandom, $urandom, $urandom, $urandom};
                bus.last_i     = 1'($urandom_range(0, 1));
            end
            bus.out_ready_i = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_dec_ark_mixw.md
Name: aes_dec_ark_mixw

Overview:
- Column-serial decryption round back-end: AddRoundKey (state XOR round key), then InvMixColumns on the 128-bit state, one 32-bit column per cycle through a single aes_inv_mixw instance.
- Sits directly downstream of the InvShiftRows/InvSubBytes stage and feeds the next decryption round or the output register.
- The final round (last_i) bypasses InvMixColumns.

Parameters:
- NCOL, 4, number of 32-bit columns per state; fixed at 4 for AES, exposed only to size the column counter.

Ports:
- clk  in  1  rising-edge clock
- nreset  in  1  asynchronous active-low reset
- in_valid_i  in  1  input block valid
- in_ready_o  out  1  stage can accept a block this cycle
- state_i  in  128  post-InvSubBytes state; column c = bits [127-32c : 96-32c]; row 0 byte = MSB of each column
- key_i  in  128  round key, same layout, sampled with state_i
- last_i  in  1  final round: skip InvMixColumns, sampled with state_i
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- state_o  out  128  round result

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: FSM goes to IDLE; col_cnt=0; the internal buffer, state_o and last flag clear to 0.
  - Outputs during reset: out_valid_o=0, in_ready_o=1 (as IDLE).
  - Reset mid-MIX or mid-DONE discards the block; no partial output ever appears.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i: buf <= state_i ^ key_i, col_cnt <= 0. Go to DONE if last_i, else MIX.
  - MIX: in_ready_o=0. Each cycle: buf column col_cnt <= inv_mixw(buf column col_cnt); col_cnt++. After column 3, col_cnt wraps to 0 and the FSM goes to DONE.
  - DONE: out_valid_o=1, state_o=buf; data held stable while out_ready_i=0.
    - in_ready_o = out_ready_i (combinational). Back-to-back handoff is allowed.
    - out_ready_i & in_valid_i: load the new block (same rule as IDLE) and go to MIX or stay in DONE per the new last_i.
    - out_ready_i & !in_valid_i: go to IDLE.
- Latency, accept edge to out_valid_o=1:
  - Non-last block: 5 cycles (1 ARK load plus 4 MIX).
  - last_i block: 1 cycle.
- Throughput:
  - Non-last: 1 block per 5 cycles with out_ready_i held high.
  - Last: 1 block per cycle.
- Columns are updated in place. Untouched columns keep their ARK value until processed.
- Processing is strictly column 0 to column 3. No reordering.
- state_o is registered: driven from buf, valid only while out_valid_o=1.
- Inputs are ignored whenever in_ready_o=0. The upstream stage must hold state_i/key_i/last_i stable while in_valid_i=1 and in_ready_o=0.
- Outputs follow valid/ready semantics: once out_valid_o rises it stays high until the out_valid_o & out_ready_i handshake.
- All arithmetic is GF(2^8) with polynomial 0x11b. XOR only; no carries.

Test Plan:
- Known-answer, key=0, last_i=0:
  - Stimulus: state_i = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Response: out_valid_o rises 5 cycles after accept; state_o = db135345_f20a225c_01010101_c6c6c6c6.
- ARK only, last_i=1:
  - Stimulus: state_i = 00112233_44556677_8899aabb_ccddeeff, key_i = 000102030405060708090a0b0c0d0e0f.
  - Response: 1 cycle later, state_o = 00102030_40506070_8090a0b0_c0d0e0f0.
- Combined:
  - Stimulus: last_i=0, key_i = 8e4da1bc_00000000_00000000_00000000, state_i = 0.
  - Response: column 0 = db135345, others 00000000.
- Backpressure:
  - Stimulus: hold out_ready_i=0 for 10 cycles after out_valid_o.
  - Response: state_o stable, in_ready_o=0, a pending in_valid_i is not taken. Release out_ready_i with in_valid_i=1: the next block is accepted in the same cycle; out_valid_o drops the next cycle and re-rises 5 cycles later.
- Back-to-back last_i blocks:
  - Stimulus: in_valid_i, out_ready_i and last_i all held high.
  - Response: one result per cycle, each equal to its state^key, none dropped or duplicated.
- Async reset:
  - Stimulus: assert nreset low during MIX col_cnt=2, mid-cycle.
  - Response: out_valid_o=0 immediately, in_ready_o=1 after release, state_o=0. A fresh block after reset gives the first known-answer result.
